// File: rtl/mcp3202_chan_sequencer.sv
// MCP3202 frame scheduler: runs one conversion per enabled channel on each frame tick
// and streams channel-tagged results out of a small FIFO on AXI4-Stream.
module mcp3202_chan_sequencer #(
    parameter int unsigned FCLK        = 100_000_000,
    parameter int unsigned FSMPL       = 500,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  chan_en,
    input  logic        diff_mode,
    input  logic        err_clr,
    output logic        conv_start,
    output logic        conv_sgl,
    output logic        conv_odd,
    input  logic        conv_busy,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        overrun,
    output logic        timeout_err,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned PERIOD = FCLK / FSMPL;
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] TERM   = TW'(PERIOD - 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_NEXT
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     mask_q, mask_d;
    logic           diff_q, diff_d;
    logic           ch_q, ch_d;
    logic [11:0]    data_q, data_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic           ovr_q, ovr_d;
    logic           tmo_q, tmo_d;
    logic [7:0]     drop_q, drop_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [16:0]    mem_q [FIFO_DEPTH];

    logic tick;
    logic push;
    logic tmo_set;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;
    logic [16:0] push_word;

    assign tick = en && (timer_q == TERM);

    always_comb begin
        timer_d = '0;
        if (en && !tick) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        diff_d     = diff_q;
        ch_d       = ch_q;
        data_d     = data_q;
        wd_d       = wd_q;
        conv_start = 1'b0;
        conv_sgl   = 1'b0;
        conv_odd   = 1'b0;
        push       = 1'b0;
        tmo_set    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick && (chan_en != 2'b00)) begin
                    mask_d  = chan_en;
                    diff_d  = diff_mode;
                    ch_d    = ~chan_en[0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!conv_busy) begin
                    conv_start = 1'b1;
                    conv_sgl   = ~diff_q;
                    conv_odd   = ch_q;
                    wd_d       = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // a result arriving on the last watchdog cycle is still taken
                if (conv_done) begin
                    data_d  = conv_data;
                    state_d = S_STORE;
                end else if (wd_q == WD_MAX) begin
                    tmo_set = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_STORE: begin
                push    = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (!ch_q && mask_q[1] && en) begin
                    ch_d    = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push_word = {ch_q | ~mask_q[1], 3'b000, ch_q, data_q};

    assign pop     = (cnt_q != '0) && m_axis_tready;
    assign full    = (cnt_q == FULL_N);
    assign push_ok = push && (!full || pop);
    assign drop    = push && !push_ok;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // a new error event in the same cycle as err_clr keeps the flag set
    always_comb begin
        ovr_d  = ovr_q;
        tmo_d  = tmo_q;
        drop_d = drop_q;
        if (err_clr) begin
            ovr_d  = 1'b0;
            tmo_d  = 1'b0;
            drop_d = '0;
        end
        if (tick && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
        if (tmo_set) begin
            tmo_d = 1'b1;
        end
        if (drop) begin
            if (err_clr) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            mask_q  <= '0;
            diff_q  <= 1'b0;
            ch_q    <= 1'b0;
            data_q  <= '0;
            wd_q    <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
            drop_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mask_q  <= mask_d;
            diff_q  <= diff_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_word;
        end
    end

    assign m_axis_tvalid = (cnt_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rptr_q][15:0] : 16'h0000;
    assign m_axis_tlast  = m_axis_tvalid && mem_q[rptr_q][16];
    assign overrun       = ovr_q;
    assign timeout_err   = tmo_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_mcp3202_chan_sequencer.sv
// Directed bench for mcp3202_chan_sequencer with a behavioural engine model
// and an AXI4-Stream beat monitor.
module tb_mcp3202_chan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  chan_en = 2'b00;
    logic        diff_mode = 1'b0;
    logic        err_clr = 1'b0;
    logic        conv_start, conv_sgl, conv_odd;
    logic        m_axis_tready = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        overrun, timeout_err;
    logic [7:0]  drop_cnt;

    logic        busy_r = 1'b0;
    logic        done_r = 1'b0;
    logic [11:0] data_r = 12'h000;
    logic [11:0] seq_r = 12'h000;
    logic        odd_r = 1'b0;
    int          cnt_r = 0;
    int          n_starts = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          lat = 100;
    bit          hang = 1'b0;
    bit          mode_seq = 1'b0;

    logic [15:0] bdata[$];
    logic        blast[$];
    logic        odd_log[$];
    logic        sgl_log[$];

    int checks = 0;
    int failures = 0;

    mcp3202_chan_sequencer #(
        .FCLK(100_000_000),
        .FSMPL(50_000),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYC(20000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .chan_en(chan_en),
        .diff_mode(diff_mode),
        .err_clr(err_clr),
        .conv_start(conv_start),
        .conv_sgl(conv_sgl),
        .conv_odd(conv_odd),
        .conv_busy(busy_r),
        .conv_done(done_r),
        .conv_data(data_r),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .overrun(overrun),
        .timeout_err(timeout_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // engine model: busy from start until done, done lat cycles after start
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        done_r <= 1'b0;
        if (conv_start) begin
            busy_r    <= !hang;
            cnt_r     <= lat;
            odd_r     <= conv_odd;
            seq_r     <= 12'h100 + 12'(n_starts);
            n_starts  <= n_starts + 1;
            start_cyc <= cyc;
            odd_log.push_back(conv_odd);
            sgl_log.push_back(conv_sgl);
        end else if (busy_r) begin
            if (cnt_r <= 1) begin
                done_r <= 1'b1;
                busy_r <= 1'b0;
                data_r <= mode_seq ? seq_r : (odd_r ? 12'h123 : 12'hABC);
            end else begin
                cnt_r <= cnt_r - 1;
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            bdata.push_back(m_axis_tdata);
            blast.push_back(m_axis_tlast);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        bdata.delete();
        blast.delete();
        odd_log.delete();
        sgl_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_beats(input string tag, input int n, input int lim);
        int k;
        k = 0;
        while (bdata.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bdata.size(), n);
    endtask

    task automatic check_idle_outs(input string tag);
        chk(tag, {conv_start, conv_sgl, conv_odd, m_axis_tvalid,
                  m_axis_tdata, m_axis_tlast, overrun, timeout_err,
                  drop_cnt}, 32'h0);
    endtask

    initial begin
        int base;
        int k;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outs("reset_outs");

        // 1: both channels, single-ended
        do_reset();
        m_axis_tready = 1'b1;
        chan_en = 2'b11;
        diff_mode = 1'b0;
        lat = 100;
        en = 1'b1;
        wait_beats("t1_beats", 2, 5000);
        en = 1'b0;
        if (bdata.size() >= 2) begin
            chk("t1_d0", bdata[0], 16'h0ABC);
            chk("t1_l0", blast[0], 1'b0);
            chk("t1_d1", bdata[1], 16'h1123);
            chk("t1_l1", blast[1], 1'b1);
        end
        chk("t1_nstart", odd_log.size(), 2);
        if (odd_log.size() >= 2) begin
            chk("t1_odd", {odd_log[0], odd_log[1]}, 2'b01);
            chk("t1_sgl", {sgl_log[0], sgl_log[1]}, 2'b11);
        end

        // 2: channel 1 only, pseudo-differential
        do_reset();
        chan_en = 2'b10;
        diff_mode = 1'b1;
        en = 1'b1;
        wait_beats("t2_beats", 1, 5000);
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_nstart", odd_log.size(), 1);
        if (odd_log.size() >= 1) begin
            chk("t2_cfg", {odd_log[0], sgl_log[0]}, 2'b10);
        end
        if (bdata.size() >= 1) begin
            chk("t2_d", bdata[0], 16'h1123);
            chk("t2_l", blast[0], 1'b1);
        end

        // 3: downstream stalled, six frames into a four-entry FIFO
        do_reset();
        m_axis_tready = 1'b0;
        mode_seq = 1'b1;
        chan_en = 2'b01;
        diff_mode = 1'b0;
        base = n_starts;
        en = 1'b1;
        k = 0;
        while (n_starts < base + 6 && k < 15000) begin
            @(negedge clk);
            k++;
        end
        chk("t3_nstart", n_starts - base, 6);
        repeat (200) @(negedge clk);
        en = 1'b0;
        chk("t3_drop", drop_cnt, 8'd2);
        chk("t3_valid", m_axis_tvalid, 1'b1);
        chk("t3_head", m_axis_tdata, {4'h0, 12'h100 + 12'(base)});
        @(negedge clk);
        m_axis_tready = 1'b1;
        wait_beats("t3_beats", 4, 50);
        for (int i = 0; i < 4 && i < bdata.size(); i++) begin
            chk("t3_data", bdata[i], {4'h0, 12'h100 + 12'(base + i)});
        end
        @(negedge clk);
        chk("t3_empty", m_axis_tvalid, 1'b0);
        mode_seq = 1'b0;

        // 4: engine never answers
        do_reset();
        hang = 1'b1;
        chan_en = 2'b01;
        en = 1'b1;
        k = 0;
        while (!timeout_err && k < 25000) begin
            @(negedge clk);
            k++;
        end
        en = 1'b0;
        chk("t4_tmo", timeout_err, 1'b1);
        chk("t4_tmo_lat", cyc - start_cyc, 20001);
        repeat (5) @(negedge clk);
        chk("t4_nobeat", bdata.size(), 0);
        chk("t4_valid", m_axis_tvalid, 1'b0);
        chk("t4_nstart", odd_log.size(), 1);
        hang = 1'b0;
        en = 1'b1;
        wait_beats("t4_recover", 1, 3000);
        en = 1'b0;
        if (bdata.size() >= 1) begin
            chk("t4_rec_d", bdata[0], 16'h0ABC);
        end
        chk("t4_tmo_hold", timeout_err, 1'b1);

        // 5: frame longer than period, clear collides with new overrun
        do_reset();
        lat = 2500;
        chan_en = 2'b01;
        en = 1'b1;
        repeat (3999) @(negedge clk);
        chk("t5_pre_ovr", overrun, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_ovr", overrun, 1'b1);
        en = 1'b0;
        wait_beats("t5_beats", 1, 3000);
        if (bdata.size() >= 1) begin
            chk("t5_d", bdata[0], 16'h0ABC);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_clr", overrun, 1'b0);
        lat = 100;

        // 6: reset in WAIT with stored entries
        do_reset();
        m_axis_tready = 1'b0;
        chan_en = 2'b11;
        base = n_starts;
        en = 1'b1;
        k = 0;
        while (n_starts < base + 3 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        chk("t6_pre_valid", m_axis_tvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outs("t6_rst_outs");
        rst = 1'b0;
        m_axis_tready = 1'b1;
        clear_logs();
        wait_beats("t6_beats", 2, 5000);
        en = 1'b0;
        if (bdata.size() >= 2) begin
            chk("t6_d0", bdata[0], 16'h0ABC);
            chk("t6_d1", {blast[1], bdata[1]}, {1'b1, 16'h1123});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
